// File: rtl/ram_write_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : ram_write_arbiter
// Brief    : Buffers single-cycle RAM write pulses in a small FIFO and shares
//            the single memory port with a read port. Pending writes are
//            forwarded to reads so a read always returns the newest data.
// Revision : 1.0 - initial release
//==============================================================================
module ram_write_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  ram_clock,
    input  logic                  ram_reset,
    input  logic                  ram_write_enable,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  fifo_overflow
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_ALMOST = c_CNT_W'(FIFO_DEPTH - 1);

    // Write buffer
    logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;

    // Memory port registers
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_overflow;

    // Read pipeline: p0 captured at acceptance, p1 while memory is read
    logic                  r_p0_valid;
    logic                  r_p0_hit;
    logic [DATA_WIDTH-1:0] r_p0_data;
    logic                  r_p1_valid;
    logic                  r_p1_hit;
    logic [DATA_WIDTH-1:0] r_p1_data;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_rd_ready;
    logic                  w_read;
    logic                  w_pop;
    logic                  w_push;
    logic [FIFO_DEPTH-1:0] w_match;
    logic                  w_fwd_hit;
    logic [DATA_WIDTH-1:0] w_fwd_data;
    logic [c_PTR_W-1:0]    w_fwd_idx;

    // Reads are refused once the buffer is almost full so writes always drain
    assign w_rd_ready = (r_count < c_ALMOST);
    assign w_read     = rd_req && w_rd_ready;
    assign w_pop      = !w_read && (r_count != '0);
    assign w_push     = ram_write_enable && ((r_count < c_FULL) || w_pop);

    // A slot matches when it holds a live entry with the requested address
    for (genvar j = 0; j < FIFO_DEPTH; j++) begin : g_slot
        logic [c_PTR_W-1:0] w_age;
        assign w_age      = c_PTR_W'(j) - r_head;
        assign w_match[j] = ({1'b0, w_age} < r_count) && (r_fifo_addr[j] == rd_addr);
    end

    // Walk oldest to newest so the last match seen is the newest one
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_fwd_idx  = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_fwd_idx = r_head + c_PTR_W'(i);
            if (w_match[w_fwd_idx]) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_fifo_data[w_fwd_idx];
            end
        end
    end

    always_ff @(posedge ram_clock) begin
        if (w_push) begin
            r_fifo_addr[r_tail] <= ram_addr;
            r_fifo_data[r_tail] <= ram_data;
        end
    end

    always_ff @(posedge ram_clock) begin
        if (ram_reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_read) begin
                r_mem_we   <= 1'b0;
                r_mem_addr <= rd_addr;
            end else if (w_pop) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_fifo_addr[r_head];
                r_mem_wdata <= r_fifo_data[r_head];
            end else begin
                r_mem_we <= 1'b0;
            end

            if (ram_write_enable && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge ram_clock) begin
        if (ram_reset) begin
            r_p0_valid <= 1'b0;
            r_p0_hit   <= 1'b0;
            r_p0_data  <= '0;
            r_p1_valid <= 1'b0;
            r_p1_hit   <= 1'b0;
            r_p1_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_p0_valid <= w_read;
            r_p0_hit   <= w_read && w_fwd_hit;
            r_p0_data  <= w_fwd_data;
            r_p1_valid <= r_p0_valid;
            r_p1_hit   <= r_p0_hit;
            r_p1_data  <= r_p0_data;
            r_rd_valid <= r_p1_valid;
            if (r_p1_valid) begin
                r_rd_data <= r_p1_hit ? r_p1_data : mem_rdata;
            end
        end
    end

    assign rd_ready      = w_rd_ready;
    assign rd_valid      = r_rd_valid;
    assign rd_data       = r_rd_data;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign fifo_overflow = r_overflow;

endmodule
`default_nettype wire
